// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types, widths and helpers for mem_responder
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_t;

    // True when any address bit above the word index is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between control unit and memory responder
// Signals:
//   mem_read, mem_write  level requests, held by the requester until ready
//   addr                 byte address
//   wdata                write data
//   rdata                read data, valid while ready
//   ready                access complete, high until both requests drop
//   busy                 access accepted and in progress
//   err                  access rejected, valid with ready
// Modports: master (requester side), slave (responder side).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );

endinterface

// File: rtl/mem_word_array.sv
// rtl/mem_word_array.sv - 2**AW x 32 word storage with registered, commit-enabled read
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (read register only)
//   we, re       write / read strobes, one cycle at commit
//   idx          word index
//   wdata        write data
//   rdata        registered read data, holds its value when re is low
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**AW];

    // Storage contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 4-phase handshake memory responder with programmable latency
// Parameters: AW (word-address width), LATENCY (1..15 cycles acceptance to ready)
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     mem_responder_if.slave (requests in; rdata/ready/busy/err out)
// Build option: MEM_ALIGN_CHECK_EN rejects accesses with addr[1:0] != 0.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              reject_q, reject_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              commit;
    logic              req;
    logic              misaligned;
    logic              reject_now;
    logic [WORD_W-1:0] rdata_w;

    assign req = bus.mem_read | bus.mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = bus.addr[1:0] != 2'b00;
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus.addr[1:0];
    assign misaligned       = 1'b0;
`endif

    assign reject_now = (bus.mem_read & bus.mem_write)
                      | addr_out_of_range(bus.addr, AW)
                      | misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            reject_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            reject_q <= reject_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        reject_d = reject_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        err_d    = err_q;
        commit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // Everything about the access is frozen here; the bus is
                    // not looked at again until HOLD.
                    idx_d    = bus.addr[AW+1:2];
                    wdata_d  = bus.wdata;
                    write_d  = bus.mem_write;
                    reject_d = reject_now;
                    cnt_d    = CNT_INIT;
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    commit  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    err_d   = reject_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!req) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_word_array #(
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit &  write_q & ~reject_q),
        .re    (commit & ~write_q & ~reject_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (rdata_w)
    );

    assign bus.rdata = rdata_w;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a word-array reference model
module tb_mem_responder;

    localparam int AW      = 8;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 256;
    localparam int TMO     = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder #(.AW(AW), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    int          obs_lat;
    logic        obs_busy, obs_err, obs_hold_ok, obs_rel_ready, obs_rel_err;
    logic [31:0] obs_rdata;

    // Reference: reject on conflict, beyond the array, or (optionally) misaligned;
    // otherwise the word at addr/4 is written or read.
    task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, output logic e);
        e = (rd && wr) || (a >= 32'(DEPTH * 4));
`ifdef MEM_ALIGN_CHECK_EN
        e = e || ((a % 4) != 0);
`endif
        if (!e && wr) model_mem[int'(a / 4)] = d;
        if (!e && rd) model_rdata = model_mem[int'(a / 4)];
    endtask

    // Drives one request from an idle DUT, called #1 after a rising edge.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input int hold, input logic [31:0] d_late);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.addr      = a;
        bus.wdata     = d;
        @(posedge clk); #1;
        obs_busy = bus.busy;
        obs_lat  = -1;
        for (int n = 1; n <= TMO; n++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) begin
                obs_lat = n;
                break;
            end
        end
        obs_err     = bus.err;
        obs_rdata   = bus.rdata;
        obs_hold_ok = 1'b1;
        bus.wdata   = d_late;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.ready !== 1'b1 || bus.rdata !== obs_rdata) obs_hold_ok = 1'b0;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk); #1;
        obs_rel_ready = bus.ready;
        obs_rel_err   = bus.err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.addr = '0; bus.wdata = '0;
        model_rdata = '0;
        #12;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.busy  !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.err   !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        int   bad = 0;
        logic e;
        logic [31:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            model_access(1'b0, 1'b1, 32'(i * 4), d, e);
            run_access(1'b0, 1'b1, 32'(i * 4), d, 0, d);
            if (obs_lat != LATENCY || obs_err !== e) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL fill: got %0d bad writes expected 0", bad); end
    endtask

    task automatic test_write_read();
        logic e;
        model_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, e);
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", obs_busy); end
        checks++; if (obs_lat != LATENCY) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", obs_lat, LATENCY); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", obs_err); end
        checks++; if (obs_rel_ready !== 1'b0) begin errors++; $display("FAIL wr_release: got %b expected 0", obs_rel_ready); end
        model_access(1'b1, 1'b0, 32'h10, 32'h0, e);
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0);
        checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", obs_err); end
    endtask

    task automatic test_conflict();
        logic e;
        logic [31:0] prev_rdata;
        prev_rdata = model_rdata;
        model_access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, e);
        run_access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 0, 32'hCAFEF00D);
        checks++; if (obs_lat != LATENCY) begin errors++; $display("FAIL conflict_ready: got %0d expected %0d", obs_lat, LATENCY); end
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b expected 1", obs_err); end
        checks++; if (obs_rdata !== prev_rdata) begin errors++; $display("FAIL conflict_rdata: got %h expected %h", obs_rdata, prev_rdata); end
        checks++; if (obs_rel_err !== 1'b0) begin errors++; $display("FAIL conflict_err_clear: got %b expected 0", obs_rel_err); end
        model_access(1'b1, 1'b0, 32'h20, 32'h0, e);
        run_access(1'b1, 1'b0, 32'h20, 32'h0, 0, 32'h0);
        checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL conflict_readback: got %h expected %h", obs_rdata, model_rdata); end
    endtask

    task automatic test_range();
        logic e;
        logic [31:0] prev_rdata;
        prev_rdata = model_rdata;
        model_access(1'b1, 1'b0, 32'h400, 32'h0, e);
        run_access(1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h0);
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL oob_err: got %b expected 1", obs_err); end
        checks++; if (obs_rdata !== prev_rdata) begin errors++; $display("FAIL oob_rdata: got %h expected %h", obs_rdata, prev_rdata); end
        model_access(1'b1, 1'b0, 32'h3FC, 32'h0, e);
        run_access(1'b1, 1'b0, 32'h3FC, 32'h0, 0, 32'h0);
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b expected 0", obs_err); end
        checks++; if (obs_rdata !== model_mem[DEPTH-1]) begin errors++; $display("FAIL last_word_data: got %h expected %h", obs_rdata, model_mem[DEPTH-1]); end
    endtask

    task automatic test_abort();
        logic e;
        model_access(1'b0, 1'b1, 32'h30, 32'hEDCBA987, e);
        run_access(1'b0, 1'b1, 32'h30, 32'hEDCBA987, 0, 32'hEDCBA987);
        bus.mem_write = 1'b1;
        bus.addr      = 32'h30;
        bus.wdata     = 32'h12345678;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_rdata = '0;
        #1;
        checks++; if ({bus.ready, bus.busy, bus.err} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b expected 000", {bus.ready, bus.busy, bus.err}); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", bus.rdata); end
        @(posedge clk); #1;
        bus.mem_write = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_access(1'b1, 1'b0, 32'h30, 32'h0, e);
        run_access(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0);
        checks++; if (obs_rdata !== model_rdata || obs_rdata === 32'h12345678) begin errors++; $display("FAIL abort_readback: got %h expected %h", obs_rdata, model_rdata); end
    endtask

    task automatic test_back_to_back();
        logic e;
        model_access(1'b0, 1'b1, 32'h40, 32'hA5A5_0001, e);
        run_access(1'b0, 1'b1, 32'h40, 32'hA5A5_0001, 5, 32'h5A5A_FFFF);
        checks++; if (obs_hold_ok !== 1'b1) begin errors++; $display("FAIL hold_ready: got %b expected 1", obs_hold_ok); end
        checks++; if (obs_rel_ready !== 1'b0) begin errors++; $display("FAIL hold_release: got %b expected 0", obs_rel_ready); end
        model_access(1'b1, 1'b0, 32'h40, 32'h0, e);
        run_access(1'b1, 1'b0, 32'h40, 32'h0, 5, 32'h0);
        checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", obs_busy); end
        checks++; if (obs_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_data: got %h expected a5a50001", obs_rdata); end
        checks++; if (obs_hold_ok !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b expected 1", obs_hold_ok); end
    endtask

    task automatic test_align();
        logic e;
        model_access(1'b1, 1'b0, 32'h11, 32'h0, e);
        run_access(1'b1, 1'b0, 32'h11, 32'h0, 0, 32'h0);
        checks++; if (obs_err !== e) begin errors++; $display("FAIL align_err: got %b expected %b", obs_err, e); end
        checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL align_data: got %h expected %h", obs_rdata, model_rdata); end
    endtask

    task automatic test_random();
        logic e;
        bit   rd, wr;
        logic [31:0] a, d;
        int   kind, hold;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, DEPTH * 4 - 1));
            d    = $urandom;
            hold = $urandom_range(0, 2);
            rd   = 1'b0;
            wr   = 1'b0;
            if (kind == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else if (kind == 1) begin
                rd = 1'b1;
                a  = a + 32'(DEPTH * 4) * 32'($urandom_range(1, 1000));
            end else if (kind < 6) begin
                rd = 1'b1;
            end else begin
                wr = 1'b1;
            end
            model_access(rd, wr, a, d, e);
            run_access(rd, wr, a, d, hold, ~d);
            checks++; if (obs_lat != LATENCY) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, obs_lat, LATENCY); end
            checks++; if (obs_err !== e) begin errors++; $display("FAIL rand_err[%0d]: addr %h got %b expected %b", i, a, obs_err, e); end
            checks++; if (obs_rdata !== model_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: addr %h got %h expected %h", i, a, obs_rdata, model_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_conflict();
        test_range();
        test_abort();
        test_back_to_back();
        test_align();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
